// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and constants for the RO-PUF challenge sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package puf_challenge_sequencer_pkg;

    // Sequencer phases, one per step of a challenge plus run bookends.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_HOLD    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    // Counter clear time after a select change.
    localparam int unsigned CLEAR_CYCLES = 2;
    // Quiet time after the enable drops, before the counts are sampled.
    localparam int unsigned HOLD_CYCLES  = 3;

    // Oscillator index for challenge k: (base + stride + k) mod n_ro.
    // Mux-1 uses stride = 0; mux-2 uses the programmed stride.
    function automatic int unsigned challenge_index(
        input int unsigned base,
        input int unsigned stride,
        input int unsigned k,
        input int unsigned n_ro
    );
        return (base + stride + k) % n_ro;
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Control/datapath bundle between the front end, the sequencer and the RO bank.
// Latency: none (wires only).
// Backpressure: none; start/abort are single-cycle requests, busy reports run state.
//   master: front end + oscillator bank side (drives start/abort/base/stride/window_len/cnt1/cnt2)
//   slave : the sequencer (drives sel1/sel2/ro_enable/ro_reset/busy/done/err/response[/sat])
// Optional: PUF_SATURATION_CHECK_EN adds the sat vector.
interface puf_challenge_sequencer_if #(
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 12,
    parameter int WIN_W     = 12,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic                 abort;
    logic [SEL_W-1:0]     base;
    logic [SEL_W-1:0]     stride;
    logic [WIN_W-1:0]     window_len;
    logic [CNT_W-1:0]     cnt1;
    logic [CNT_W-1:0]     cnt2;
    logic [SEL_W-1:0]     sel1;
    logic [SEL_W-1:0]     sel2;
    logic                 ro_enable;
    logic                 ro_reset;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [RESP_BITS-1:0] response;
`ifdef PUF_SATURATION_CHECK_EN
    logic [RESP_BITS-1:0] sat;
`endif

    modport master (
        output start, abort, base, stride, window_len, cnt1, cnt2,
        input  sel1, sel2, ro_enable, ro_reset, busy, done, err, response
`ifdef PUF_SATURATION_CHECK_EN
        , input sat
`endif
    );

    modport slave (
        input  start, abort, base, stride, window_len, cnt1, cnt2,
        output sel1, sel2, ro_enable, ro_reset, busy, done, err, response
`ifdef PUF_SATURATION_CHECK_EN
        , output sat
`endif
    );

endinterface

// File: rtl/puf_phase_timer.sv
// Loadable down-counter timing the CLEAR/SETTLE/MEASURE/HOLD phases; zero flag ends a phase.
// Latency: load value N-1 gives zero_o exactly N cycles after the load edge.
// Backpressure: none; load_i always wins, otherwise counts down and parks at zero.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i, load_val_i : reload request and value;  zero_o : count is zero
module puf_phase_timer #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// RO-PUF challenge sequencer: steps RESP_BITS challenge pairs, measures each pair, builds the response.
// Latency: done RESP_BITS*(6+SETTLE_CYCLES+max(window_len,1))+1 cycles after the start cycle; outputs registered.
// Backpressure: start ignored while busy; abort returns to IDLE next cycle keeping captured bits.
//   clock, reset (async active-low); bus: slave side of puf_challenge_sequencer_if.
// Optional: PUF_SATURATION_CHECK_EN adds bus.sat (per-bit flag: a count was all-ones at capture).
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int N_RO          = 16,
    parameter int SEL_W         = 4,
    parameter int CNT_W         = 12,
    parameter int WIN_W         = 12,
    parameter int RESP_BITS     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    puf_challenge_sequencer_if.slave bus
);

    localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    seq_state_t           state_q;
    logic [K_W-1:0]       k_q;
    logic [SEL_W-1:0]     base_q;
    logic [SEL_W-1:0]     stride_q;
    logic [WIN_W-1:0]     win_m1_q;     // measurement window minus one (timer load value)
    logic [SEL_W-1:0]     sel1_q;
    logic [SEL_W-1:0]     sel2_q;
    logic                 en_q;
    logic                 rst_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [RESP_BITS-1:0] resp_q;
`ifdef PUF_SATURATION_CHECK_EN
    logic [RESP_BITS-1:0] sat_q;
`endif

    logic [CNT_W-1:0]     cnt1;
    logic [CNT_W-1:0]     cnt2;
    logic                 accept;
    logic                 last_k;
    logic [WIN_W-1:0]     win_m1_d;
    logic                 tmr_load;
    logic [WIN_W-1:0]     tmr_val;
    logic                 tmr_zero;

    function automatic logic [SEL_W-1:0] sel_of(
        input logic [SEL_W-1:0] b,
        input logic [SEL_W-1:0] s,
        input int unsigned      k
    );
        return SEL_W'(challenge_index(32'(b), 32'(s), k, N_RO));
    endfunction

    assign cnt1     = bus.cnt1;
    assign cnt2     = bus.cnt2;
    assign accept   = (state_q == ST_IDLE) && bus.start && (bus.stride != '0);
    assign last_k   = (k_q == K_W'(RESP_BITS - 1));
    // window_len = 0 still gives a one-cycle window.
    assign win_m1_d = (bus.window_len == '0) ? '0 : bus.window_len - WIN_W'(1);

    // Timer reload must coincide with the state transition it times, so it is
    // decoded combinationally from the current state and the zero flag.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = win_m1_q;
                end
            end
            ST_MEASURE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(HOLD_CYCLES - 1);
                end
            end
            ST_CAPTURE: begin
                if (!last_k) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(CLEAR_CYCLES - 1);
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    puf_phase_timer #(
        .W (WIN_W)
    ) u_phase_timer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Outputs are set on the transition into each state, so every output is a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            base_q   <= '0;
            stride_q <= '0;
            win_m1_q <= '0;
            sel1_q   <= '0;
            sel2_q   <= '0;
            en_q     <= 1'b0;
            rst_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            resp_q   <= '0;
`ifdef PUF_SATURATION_CHECK_EN
            sat_q    <= '0;
`endif
        end else if ((state_q != ST_IDLE) && bus.abort) begin
            // Captured bits stay; the in-flight challenge is dropped.
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.stride != '0) begin
                            state_q  <= ST_CLEAR;
                            base_q   <= bus.base;
                            stride_q <= bus.stride;
                            win_m1_q <= win_m1_d;
                            k_q      <= '0;
                            sel1_q   <= sel_of(bus.base, '0, 0);
                            sel2_q   <= sel_of(bus.base, bus.stride, 0);
                            resp_q   <= '0;
`ifdef PUF_SATURATION_CHECK_EN
                            sat_q    <= '0;
`endif
                            err_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            rst_q    <= 1'b1;
                            en_q     <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (tmr_zero) begin
                        state_q <= ST_SETTLE;
                        rst_q   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= ST_MEASURE;
                        en_q    <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (tmr_zero) begin
                        state_q <= ST_HOLD;
                        en_q    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // Ties resolve to 1.
                    resp_q[k_q] <= (cnt1 >= cnt2);
`ifdef PUF_SATURATION_CHECK_EN
                    sat_q[k_q]  <= (cnt1 == '1) || (cnt2 == '1);
`endif
                    if (last_k) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_CLEAR;
                        k_q     <= k_q + K_W'(1);
                        sel1_q  <= sel_of(base_q, '0, 32'(k_q) + 32'd1);
                        sel2_q  <= sel_of(base_q, stride_q, 32'(k_q) + 32'd1);
                        rst_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    rst_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    rst_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel1      = sel1_q;
    assign bus.sel2      = sel2_q;
    assign bus.ro_enable = en_q;
    assign bus.ro_reset  = rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.response  = resp_q;
`ifdef PUF_SATURATION_CHECK_EN
    assign bus.sat       = sat_q;
`endif

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: directed runs, scoreboard queues checked by negedge monitors.
// Oscillator counts come from per-challenge tables indexed by the current mux-1 select.
// Optional: PUF_SATURATION_CHECK_EN also checks the sat vector.
module tb_puf_challenge_sequencer;

    localparam int N_RO          = 16;
    localparam int SEL_W         = 4;
    localparam int CNT_W         = 12;
    localparam int WIN_W         = 12;
    localparam int RESP_BITS     = 8;
    localparam int SETTLE_CYCLES = 4;

    logic clock = 1'b0;
    logic reset;

    initial forever #5 clock = ~clock;

    puf_challenge_sequencer_if #(
        .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RESP_BITS)
    ) bus ();

    puf_challenge_sequencer #(
        .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W),
        .RESP_BITS(RESP_BITS), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    typedef struct {
        logic [7:0] resp;
        logic [7:0] sat;
        int         cyc;
    } done_exp_t;

    typedef struct {
        logic [3:0] s1;
        logic [3:0] s2;
        int         w;
    } ch_exp_t;

    done_exp_t done_q[$];
    ch_exp_t   ch_q[$];

    // Oscillator bank model: counts for challenge k, k recovered from sel1.
    logic [CNT_W-1:0] c1_tab [RESP_BITS];
    logic [CNT_W-1:0] c2_tab [RESP_BITS];
    logic [SEL_W-1:0] run_base = '0;
    logic [SEL_W-1:0] cur_k;

    assign cur_k    = bus.sel1 - run_base;
    assign bus.cnt1 = c1_tab[cur_k[2:0]];
    assign bus.cnt2 = c2_tab[cur_k[2:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic push_ch(input logic [3:0] s1, input logic [3:0] s2, input int w);
        ch_exp_t e;
        e.s1 = s1;
        e.s2 = s2;
        e.w  = w;
        ch_q.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] resp, input logic [7:0] sat, input int c);
        done_exp_t e;
        e.resp = resp;
        e.sat  = sat;
        e.cyc  = c;
        done_q.push_back(e);
    endtask

    // Drives start for one cycle; c0 is the cycle number of the start cycle.
    task automatic start_run(input logic [3:0] b, input logic [3:0] s, input logic [11:0] win,
                             input logic with_abort, output int c0);
        @(posedge clock);
        #1;
        bus.base       = b;
        bus.stride     = s;
        bus.window_len = win;
        bus.start      = 1'b1;
        bus.abort      = with_abort;
        c0             = cyc;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_q.size() == 0 && ch_q.size() == 0) break;
        end
        check("drain", 32'(done_q.size() + ch_q.size()), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    // Done monitor: every done pulse must match the next expected run result.
    initial forever begin
        done_exp_t e;
        @(negedge clock);
        if (reset === 1'b1 && bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = done_q.pop_front();
                check("response", 32'(bus.response), 32'(e.resp));
                check("done_cycle", cyc, e.cyc);
`ifdef PUF_SATURATION_CHECK_EN
                check("sat", 32'(bus.sat), 32'(e.sat));
`endif
            end
        end
    end

    // Enable monitor: each enable window must use the expected pair and length.
    initial begin
        logic       en_prev;
        int         en_len;
        logic [3:0] m_s1;
        logic [3:0] m_s2;
        ch_exp_t    e;
        en_prev = 1'b0;
        en_len  = 0;
        m_s1    = '0;
        m_s2    = '0;
        forever begin
            @(negedge clock);
            if (bus.ro_enable === 1'b1) begin
                if (!en_prev) begin
                    m_s1   = bus.sel1;
                    m_s2   = bus.sel2;
                    en_len = 1;
                end else begin
                    en_len++;
                end
            end else if (en_prev) begin
                if (ch_q.size() == 0) begin
                    check("unexpected_enable", 32'd1, 32'd0);
                end else begin
                    e = ch_q.pop_front();
                    check("sel1", 32'(m_s1), 32'(e.s1));
                    check("sel2", 32'(m_s2), 32'(e.s2));
                    check("enable_len", en_len, e.w);
                end
            end
            en_prev = (bus.ro_enable === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.base       = '0;
        bus.stride     = '0;
        bus.window_len = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
            c1_tab[i] = '0;
            c2_tab[i] = '0;
        end
        reset = 1'b1;
        #2 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_sel1", 32'(bus.sel1), 32'd0);
        check("rst_sel2", 32'(bus.sel2), 32'd0);
        check("rst_ro_enable", 32'(bus.ro_enable), 32'd0);
        check("rst_ro_reset", 32'(bus.ro_reset), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_response", 32'(bus.response), 32'd0);
`ifdef PUF_SATURATION_CHECK_EN
        check("rst_sat", 32'(bus.sat), 32'd0);
`endif
        @(posedge clock);
        #1 reset = 1'b1;

        // stride = 0: error, no run
        start_run(4'd5, 4'd0, 12'd10, 1'b0, c0);
        @(negedge clock);
        check("s0_err", 32'(bus.err), 32'd1);
        check("s0_busy", 32'(bus.busy), 32'd0);
        check("s0_ro_reset", 32'(bus.ro_reset), 32'd1);
        check("s0_ro_enable", 32'(bus.ro_enable), 32'd0);
        check("s0_sel1", 32'(bus.sel1), 32'd0);
        check("s0_sel2", 32'(bus.sel2), 32'd0);
        check("s0_response", 32'(bus.response), 32'd0);
        repeat (3) @(negedge clock);
        check("s0_busy_later", 32'(bus.busy), 32'd0);
        check("s0_err_sticky", 32'(bus.err), 32'd1);

        // base 0, stride 1, window 0 (W=1), start pulsed during MEASURE of k=0
        // c2 = 40,60,50,51,49,0,FFF,50 vs c1 = 50 -> bits 1,0,1,0,1,1,0,1 = B5; sat bit 6
        run_base = 4'd0;
        for (int i = 0; i < RESP_BITS; i++) c1_tab[i] = 12'd50;
        c2_tab[0] = 12'd40;  c2_tab[1] = 12'd60;  c2_tab[2] = 12'd50;   c2_tab[3] = 12'd51;
        c2_tab[4] = 12'd49;  c2_tab[5] = 12'd0;   c2_tab[6] = 12'hFFF;  c2_tab[7] = 12'd50;
        for (int k = 0; k < RESP_BITS; k++) push_ch(4'(k), 4'(k + 1), 1);
        start_run(4'd0, 4'd1, 12'd0, 1'b0, c0);
        push_done(8'hB5, 8'h40, c0 + 89);
        @(negedge clock);
        check("s1_err_cleared", 32'(bus.err), 32'd0);
        check("s1_busy", 32'(bus.busy), 32'd1);
        repeat (6) @(posedge clock);
        #1;
        check("s1_in_measure", 32'(bus.ro_enable), 32'd1);
        bus.base       = 4'd9;
        bus.stride     = 4'd2;
        bus.window_len = 12'd5;
        bus.start      = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        drain(300);

        // base 3, stride 5, window 10: pairs (3,8)..(10,15), FF, done 161; cnt1 saturates on k=4
        run_base = 4'd3;
        for (int i = 0; i < RESP_BITS; i++) begin
            c1_tab[i] = 12'd100;
            c2_tab[i] = 12'd90;
        end
        c1_tab[4] = 12'hFFF;
        for (int k = 0; k < RESP_BITS; k++) push_ch(4'(3 + k), 4'(8 + k), 10);
        start_run(4'd3, 4'd5, 12'd10, 1'b0, c0);
        push_done(8'hFF, 8'h10, c0 + 161);
        drain(400);

        // base 14, stride 3, window 2, start+abort together (start wins): 55, done 97
        run_base = 4'd14;
        for (int i = 0; i < RESP_BITS; i++) begin
            if (i % 2 == 0) begin
                c1_tab[i] = 12'd200;
                c2_tab[i] = 12'd200;
            end else begin
                c1_tab[i] = 12'd100;
                c2_tab[i] = 12'd300;
            end
        end
        for (int k = 0; k < RESP_BITS; k++) push_ch(4'(14 + k), 4'(1 + k), 2);
        start_run(4'd14, 4'd3, 12'd2, 1'b1, c0);
        push_done(8'h55, 8'h00, c0 + 97);
        @(negedge clock);
        check("s3_start_wins_busy", 32'(bus.busy), 32'd1);
        drain(300);

        // Abort during MEASURE of k=2 (4th enable cycle): bits 0..1 kept, no done
        run_base = 4'd3;
        for (int i = 0; i < RESP_BITS; i++) begin
            c1_tab[i] = 12'd100;
            c2_tab[i] = 12'd90;
        end
        push_ch(4'd3, 4'd8, 10);
        push_ch(4'd4, 4'd9, 10);
        push_ch(4'd5, 4'd10, 4);
        start_run(4'd3, 4'd5, 12'd10, 1'b0, c0);
        repeat (49) @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        @(negedge clock);
        check("ab_ro_enable", 32'(bus.ro_enable), 32'd0);
        check("ab_ro_reset", 32'(bus.ro_reset), 32'd1);
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_done", 32'(bus.done), 32'd0);
        check("ab_response", 32'(bus.response), 32'h03);
`ifdef PUF_SATURATION_CHECK_EN
        check("ab_sat", 32'(bus.sat), 32'd0);
`endif
        repeat (200) @(negedge clock);
        drain(10);

        // Abort in IDLE has no effect
        @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        @(negedge clock);
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_abort_response", 32'(bus.response), 32'h03);
        check("idle_abort_ro_reset", 32'(bus.ro_reset), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
